// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths, FSM states and the restoring step for seq_divider
package parametr;

    localparam int size    = 8;
    localparam int outsize = 2 * size;
    localparam int cnt_w   = $clog2(outsize + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic            qbit;
        logic [size:0]   rem;
    } step_t;

    // One restoring step: bring in the next dividend bit, keep the difference
    // only when it does not borrow.
    function automatic step_t restore_step(
        input logic [size:0]   rem,
        input logic            din,
        input logic [size-1:0] dvs
    );
        logic [size+1:0] shifted;
        logic [size+1:0] trial;
        step_t           s;
        shifted = {rem, din};
        trial   = shifted - {2'b00, dvs};
        if (!trial[size+1]) begin
            s.rem  = trial[size:0];
            s.qbit = 1'b1;
        end else begin
            s.rem  = shifted[size:0];
            s.qbit = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_divider
    import parametr::*;
(
    input  logic               clc,
    input  logic               rst,
    input  logic               start,
    input  logic [outsize-1:0] dividend,
    input  logic [size-1:0]    divisor,
    output logic               busy,
    output logic               done,
    output logic [outsize-1:0] quotient,
    output logic [size-1:0]    remainder,
    output logic               div_zero
);

    state_t             state;
    logic [cnt_w-1:0]   cnt;
    logic [outsize-1:0] dvd_q;
    logic [size-1:0]    dvs_q;
    logic [size:0]      prem;
    logic               zero_q;
    step_t              st;

    // dvd_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    always_comb begin
        st = restore_step(prem, dvd_q[outsize-1], dvs_q);
    end

    always_ff @(posedge clc or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem      <= '0;
            zero_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= CALC;
                        dvd_q <= dividend;
                        prem  <= '0;
                        if (divisor == '0) begin
                            // Zero divisor spends a single CALC cycle so done lands after edge 1.
                            zero_q <= 1'b1;
                            dvs_q  <= '0;
                            cnt    <= cnt_w'(1);
                        end else begin
                            zero_q   <= 1'b0;
                            div_zero <= 1'b0;
                            dvs_q    <= divisor;
                            cnt      <= cnt_w'(outsize);
                        end
                    end
                end
                CALC: begin
                    if (zero_q) begin
                        quotient  <= '1;
                        remainder <= dvd_q[size-1:0];
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        dvd_q <= {dvd_q[outsize-2:0], st.qbit};
                        prem  <= st.rem;
                        cnt   <= cnt - cnt_w'(1);
                        if (cnt == cnt_w'(1)) begin
                            quotient  <= {dvd_q[outsize-2:0], st.qbit};
                            remainder <= st.rem[size-1:0];
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

    logic        clc;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    seq_divider dut (
        .clc       (clc),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clc = 1'b0;
    always #5 clc = ~clc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        if (dvs == 8'd0) begin
            e.q  = 16'hFFFF;
            e.r  = dvd[7:0];
            e.dz = 1'b1;
        end else begin
            e.q  = dvd / {8'd0, dvs};
            e.r  = 8'(dvd % {8'd0, dvs});
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clc) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("extra_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                chk("busy_in_done", busy, 1);
            end
        end
    end

    // Called at the negedge after the accepting edge; n counts edges since then.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clc);
            n++;
        end
    endtask

    task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        int   n;
        e = model(dvd, dvs);
        @(negedge clc);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clc);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        chk("busy_after_start", busy, 1);
        wait_done(n);
        chk("latency", n, (dvs == 8'd0) ? 1 : 16);
        @(negedge clc);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("hold_q", quotient, e.q);
        chk("hold_r", remainder, e.r);
    endtask

    initial begin
        int n;
        exp_t e;
        rst = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        repeat (2) @(negedge clc);
        rst = 1'b1;

        run_div(16'd1000, 8'd7);
        run_div(16'hFFFF, 8'd1);
        run_div(16'd100, 8'd200);
        run_div(16'd5, 8'd0);
        chk("dz_hold", div_zero, 1);
        run_div(16'd1000, 8'd7);
        chk("dz_cleared", div_zero, 0);

        // Second start at edge 5 and another during DONE must both be ignored.
        @(negedge clc);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        sb.push_back(model(16'd1000, 8'd7));
        @(negedge clc);
        start = 1'b0;
        repeat (4) @(negedge clc);
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clc);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clc);
            n++;
        end
        chk("busy_latency", n + 5, 16);
        dividend = 16'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clc);
        start = 1'b0;
        chk("ignore_in_done", busy, 0);
        chk("ignore_q", quotient, 142);

        // Reset in the middle of a run.
        @(negedge clc);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        sb.push_back(model(16'd1000, 8'd7));
        @(negedge clc);
        start = 1'b0;
        repeat (7) @(negedge clc);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_dz", div_zero, 0);
        sb.delete();
        repeat (3) @(negedge clc);
        rst      = 1'b1;
        dividend = 16'd300;
        divisor  = 8'd9;
        start    = 1'b1;
        sb.push_back(model(16'd300, 8'd9));
        @(negedge clc);
        start = 1'b0;
        chk("first_edge_accept", busy, 1);
        wait_done(n);
        chk("post_rst_latency", n, 16);
        @(negedge clc);

        for (int i = 0; i < 1000; i++) begin
            int a, b, c;
            a = $urandom_range(1, 255);
            b = $urandom_range(1, 255);
            c = $urandom_range(0, b - 1);
            e = model(16'(a * b + c), 8'(b));
            chk("rt_model_q", e.q, a);
            run_div(16'(a * b + c), 8'(b));
            chk("rt_q", quotient, a);
            chk("rt_r", remainder, c);
        end

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
